// File: rtl/hub75_deshift_pkg.sv
// Default geometry for the HUB75 column deserialiser.
// The FSM encoding stays private to the module.
package hub75_deshift_pkg;

  localparam int DEF_N_BANKS  = 2;
  localparam int DEF_N_COLS   = 64;
  localparam int DEF_N_CHANS  = 3;
  localparam int DEF_N_PLANES = 8;
  localparam int DEF_GAP_MAX  = 16;

endpackage

// File: rtl/hub75_deshift.sv
// Captures one HUB75 line of serial column strobes into bit-plane RAM writes.
// Latency: write one cycle after each accepted strobe; no backpressure, strobes while idle flag overrun.
module hub75_deshift
  import hub75_deshift_pkg::*;
#(
  parameter int N_BANKS    = DEF_N_BANKS,
  parameter int N_COLS     = DEF_N_COLS,
  parameter int N_CHANS    = DEF_N_CHANS,
  parameter int N_PLANES   = DEF_N_PLANES,
  parameter int GAP_MAX    = DEF_GAP_MAX,
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_BANKS*N_CHANS-1:0]            phy_data,
  input  logic                                  phy_clk,
  output logic [N_BANKS*N_CHANS*N_PLANES-1:0]   ram_data,
  output logic [N_BANKS*N_CHANS*N_PLANES-1:0]   ram_mask,
  output logic [LOG_N_COLS-1:0]                 ram_col_addr,
  output logic                                  ram_wren,
  input  logic [N_PLANES-1:0]                   ctrl_plane,
  input  logic                                  ctrl_arm,
  input  logic                                  ctrl_abort,
  output logic                                  ctrl_rdy,
  output logic                                  ctrl_done,
  output logic                                  stat_short,
  output logic                                  stat_overrun
);

  localparam int N_FIELDS = N_BANKS * N_CHANS;
  localparam int COL_W    = LOG_N_COLS + 1;
  localparam int GAP_W    = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPT} state_t;

  state_t                state, state_nxt;
  logic [COL_W-1:0]      col;
  logic [GAP_W-1:0]      gap;
  logic [N_PLANES-1:0]   plane;
  logic [N_FIELDS-1:0]   data_q;
  logic [LOG_N_COLS-1:0] addr_q;
  logic                  wr_q, done_q, short_q, overrun_q;
  logic                  accept, last, timeout, arm;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Abort is tested first so it wins over a strobe or a gap timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    arm       = 1'b0;
    last      = (col == COL_W'(N_COLS - 1));
    unique case (state)
      IDLE: begin
        if (ctrl_arm) begin
          arm       = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (ctrl_abort) state_nxt = IDLE;
        else if (phy_clk) begin
          accept    = 1'b1;
          state_nxt = last ? IDLE : CAPT;
        end
      end
      CAPT: begin
        if (ctrl_abort) state_nxt = IDLE;
        else if (phy_clk) begin
          accept = 1'b1;
          if (last) state_nxt = IDLE;
        end else if (gap == GAP_W'(GAP_MAX - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      gap       <= '0;
      plane     <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= accept;
      done_q    <= accept && last;
      short_q   <= timeout;
      overrun_q <= (state == IDLE) && phy_clk;
      if (arm) begin
        plane <= ctrl_plane;
        col   <= '0;
      end else if (accept) begin
        col <= col + 1'b1;
      end
      if (state == CAPT && !phy_clk) gap <= gap + 1'b1;
      else                            gap <= '0;
    end
  end

  // Payload only matters while ram_wren is high, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= phy_data;
    addr_q <= col[LOG_N_COLS-1:0];
  end

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
    assign ram_data[i*N_PLANES +: N_PLANES] = {N_PLANES{data_q[i]}};
    assign ram_mask[i*N_PLANES +: N_PLANES] = plane;
  end

  assign ram_col_addr = addr_q;
  assign ram_wren     = wr_q;
  assign ctrl_done    = done_q;
  assign stat_short   = short_q;
  assign stat_overrun = overrun_q;
  assign ctrl_rdy     = (state == IDLE);

endmodule

// File: tb/tb_hub75_deshift.sv
// Bench for hub75_deshift: scenario table plus hand-written reset/overrun sequences,
// with a write scoreboard filled as strobes are driven.
module tb_hub75_deshift;

  localparam int NB = 2, NC = 64, NCH = 3, NP = 8, GM = 16, LC = 6;
  localparam int NF = NB * NCH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NF-1:0]     phy_data = '0;
  logic              phy_clk = 1'b0;
  logic [NF*NP-1:0]  ram_data, ram_mask;
  logic [LC-1:0]     ram_col_addr;
  logic              ram_wren;
  logic [NP-1:0]     ctrl_plane = '0;
  logic              ctrl_arm = 1'b0, ctrl_abort = 1'b0;
  logic              ctrl_rdy, ctrl_done, stat_short, stat_overrun;

  always #5 clk = ~clk;

  hub75_deshift #(
    .N_BANKS(NB), .N_COLS(NC), .N_CHANS(NCH), .N_PLANES(NP), .GAP_MAX(GM), .LOG_N_COLS(LC)
  ) dut (
    .clk(clk), .rst(rst), .phy_data(phy_data), .phy_clk(phy_clk),
    .ram_data(ram_data), .ram_mask(ram_mask), .ram_col_addr(ram_col_addr), .ram_wren(ram_wren),
    .ctrl_plane(ctrl_plane), .ctrl_arm(ctrl_arm), .ctrl_abort(ctrl_abort),
    .ctrl_rdy(ctrl_rdy), .ctrl_done(ctrl_done), .stat_short(stat_short), .stat_overrun(stat_overrun)
  );

  typedef struct {
    logic [LC-1:0]    addr;
    logic [NF*NP-1:0] data;
    logic [NF*NP-1:0] mask;
    logic             done;
  } wr_t;

  typedef struct {
    logic [NP-1:0] plane;
    int            lead;
    int            n_str;
    int            spacing;
    int            abort_at;
    int            tail;
    bit            noisy;
    logic [NF-1:0] xr;
    int            exp_wr;
    int            exp_done;
    int            exp_short;
    int            exp_ovr;
  } scen_t;

  wr_t   exp_q[$];
  scen_t tbl[7];
  int    total = 0, bad = 0;
  int    n_wr = 0, n_done = 0, n_short = 0, n_ovr = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic wr_t mk(input int col, input logic [NF-1:0] d, input logic [NP-1:0] pl,
                             input logic dn);
    wr_t r;
    r.addr = col[LC-1:0];
    for (int i = 0; i < NF; i++) begin
      r.data[i*NP +: NP] = d[i] ? 8'hFF : 8'h00;
      r.mask[i*NP +: NP] = pl;
    end
    r.done = dn;
    return r;
  endfunction

  task automatic sample();
    wr_t e;
    if (ram_wren === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_col_addr), 64'(e.addr));
        check("wr_data", 64'(ram_data), 64'(e.data));
        check("wr_mask", 64'(ram_mask), 64'(e.mask));
        check("wr_done", 64'(ctrl_done), 64'(e.done));
      end
    end else if (ctrl_done !== 1'b0) begin
      check("done_without_write", 64'(ctrl_done), 64'd0);
    end
    if (ctrl_done === 1'b1)    n_done++;
    if (stat_short === 1'b1)   n_short++;
    if (stat_overrun === 1'b1) n_ovr++;
  endtask

  // Sample the outputs of the last edge, then set inputs for the next edge.
  task automatic cyc(input logic s, input logic [NF-1:0] d, input logic ab, input logic ar,
                     input logic [NP-1:0] pl, input logic r);
    @(negedge clk);
    sample();
    phy_clk = s; phy_data = d; ctrl_abort = ab; ctrl_arm = ar; ctrl_plane = pl; rst = r;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int b_wr, b_done, b_short, b_ovr;
    logic [NF-1:0] d;
    //          plane  lead n_str spc abort tail noisy xr     wr  done short ovr
    tbl[0] = '{8'h04,  0,   64,   0,  -1,   4,   1'b0, 6'h00, 64, 1,   0,    0};
    tbl[1] = '{8'h01,  0,   10,   0,  -1,   20,  1'b0, 6'h2a, 10, 0,   1,    0};
    tbl[2] = '{8'h80,  0,   64,   15, -1,   4,   1'b1, 6'h15, 64, 1,   0,    0};
    tbl[3] = '{8'h10,  0,   30,   0,  20,   4,   1'b0, 6'h3f, 20, 0,   0,    9};
    tbl[4] = '{8'h02,  0,   64,   3,  63,   4,   1'b0, 6'h0c, 63, 0,   0,    0};
    tbl[5] = '{8'h40,  40,  64,   0,  -1,   4,   1'b0, 6'h33, 64, 1,   0,    0};
    tbl[6] = '{8'h20,  0,   3,    16, -1,   4,   1'b0, 6'h01, 1,  0,   1,    2};

    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle();
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_rdy", 64'(ctrl_rdy), 64'd1);
    check("rst_done", 64'(ctrl_done), 64'd0);
    check("rst_short", 64'(stat_short), 64'd0);
    check("rst_overrun", 64'(stat_overrun), 64'd0);

    // Strobe while idle.
    b_wr = n_wr;
    cyc(1'b1, 6'h3f, 1'b0, 1'b0, '0, 1'b0);
    idle();
    check("ovr_pulse", 64'(stat_overrun), 64'd1);
    check("ovr_no_wren", 64'(ram_wren), 64'd0);
    idle();
    check("ovr_clear", 64'(stat_overrun), 64'd0);
    check("ovr_rdy", 64'(ctrl_rdy), 64'd1);
    check("ovr_writes", 64'(n_wr - b_wr), 64'd0);

    for (int k = 0; k < 7; k++) begin
      int w;
      b_wr = n_wr; b_done = n_done; b_short = n_short; b_ovr = n_ovr;
      w = 0;
      while (ctrl_rdy !== 1'b1 && w < 100) begin
        idle();
        w++;
      end
      check($sformatf("s%0d_rdy_before", k), 64'(ctrl_rdy), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b1, tbl[k].plane, 1'b0);
      repeat (tbl[k].lead) idle();
      for (int j = 0; j < tbl[k].n_str; j++) begin
        d = j[NF-1:0] ^ tbl[k].xr;
        cyc(1'b1, d, (j == tbl[k].abort_at), tbl[k].noisy, tbl[k].noisy ? 8'hFF : 8'h00, 1'b0);
        if (j < tbl[k].exp_wr) exp_q.push_back(mk(j, d, tbl[k].plane, (j == NC - 1)));
        repeat (tbl[k].spacing) idle();
      end
      repeat (tbl[k].tail) idle();
      check($sformatf("s%0d_writes", k), 64'(n_wr - b_wr), 64'(tbl[k].exp_wr));
      check($sformatf("s%0d_done", k), 64'(n_done - b_done), 64'(tbl[k].exp_done));
      check($sformatf("s%0d_short", k), 64'(n_short - b_short), 64'(tbl[k].exp_short));
      check($sformatf("s%0d_overrun", k), 64'(n_ovr - b_ovr), 64'(tbl[k].exp_ovr));
      check($sformatf("s%0d_pending", k), 64'(exp_q.size()), 64'd0);
      check($sformatf("s%0d_rdy_after", k), 64'(ctrl_rdy), 64'd1);
      exp_q.delete();
    end

    // Reset landing on strobe 30 of a line.
    b_wr = n_wr; b_done = n_done;
    cyc(1'b0, '0, 1'b0, 1'b1, 8'h08, 1'b0);
    for (int j = 0; j < 30; j++) begin
      d = j[NF-1:0] ^ 6'h11;
      cyc(1'b1, d, 1'b0, 1'b0, '0, 1'b0);
      exp_q.push_back(mk(j, d, 8'h08, 1'b0));
    end
    cyc(1'b1, 6'h2a, 1'b0, 1'b0, '0, 1'b1);
    idle();
    check("rstcap_no_wren", 64'(ram_wren), 64'd0);
    check("rstcap_rdy", 64'(ctrl_rdy), 64'd1);
    check("rstcap_writes", 64'(n_wr - b_wr), 64'd30);
    check("rstcap_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) idle();
    check("rstcap_no_done", 64'(n_done - b_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
